ili9341_spi_tx: RTL and testbench
=================================

Name: ili9341_spi_tx

Overview:
- Byte-level SPI transmitter between the ILI9341 command/pixel sequencer and the panel pins.
- Accepts one {dc, data[7:0]} word per valid/ready handshake and shifts it out MSB first in SPI mode 0.
- Drives SCK, MOSI, D/C and CS_n, and returns a one-cycle done pulse per byte. The sequencer uses done to advance its command index.

Parameters:
- CLK_DIV, 2: system clocks per SCK half-period; legal range 1..255. Its counter width is derived from it.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  word offered by the sequencer
- in_ready  out  1  block can accept a word this cycle
- in_dc  in  1  D/C level for the word: 1 = data/parameter, 0 = command
- in_data  in  8  byte to send
- done  out  1  one-cycle pulse when a byte has finished on the wire
- busy  out  1  high from accept until return to IDLE
- spi_sck  out  1  serial clock, idles low
- spi_mosi  out  1  serial data
- spi_dc  out  1  D/C pin
- spi_cs_n  out  1  chip select, active-low

Behaviour:
- Reset (rst_n=0 at an edge) forces: in_ready=0, done=0, busy=0, spi_sck=0, spi_mosi=0, spi_dc=0, spi_cs_n=1, state=IDLE, counters=0.
- Reset mid-transfer aborts the byte. No done is generated and the word is discarded.
- The first cycle after reset release: in_ready=1.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_dc/in_data, set bit index=7, go to LOW.
  - LOW: spi_sck=0, spi_mosi=shift[idx], spi_cs_n=0, spi_dc=latched dc. Hold CLK_DIV cycles, then go to HIGH.
  - HIGH: spi_sck=1; MOSI and DC stable. Hold CLK_DIV cycles. If idx=0 go to HOLD, else idx-1 and go to LOW.
  - HOLD: spi_sck=0, cs_n still 0, hold CLK_DIV cycles. On the last HOLD cycle's edge, go to GAP, drive spi_cs_n=1 and pulse done=1 for exactly one cycle.
  - GAP: cs_n=1, sck=0, in_ready=0, hold CLK_DIV cycles, then go to IDLE.
- Timing:
  - Accept edge = cycle 0. The first LOW cycle is cycle 1.
  - done is high in cycle 1+17·CLK_DIV (CLK_DIV=2: cycle 35).
  - in_ready returns in cycle 1+18·CLK_DIV.
- MOSI changes only while SCK is low (at LOW entry). The panel samples on the SCK rising edge.
- in_dc/in_data are sampled only at the accept edge. Changes while busy are ignored.
- in_valid while in_ready=0 is not accepted, and the sequencer holds the word.
- busy=1 in all states except IDLE.
- spi_dc retains its last value in IDLE/GAP.
- spi_mosi returns to 0 in IDLE.

Optional Feature:
- Macro: ILI9341_SPI_BURST_EN.
- Defined:
  - in_ready is also 1 during the last HOLD cycle.
  - If in_valid is high then, the next word is latched, cs_n stays 0, done still pulses for the finished byte, and LOW for the new bit 7 starts the next cycle (GAP skipped).
  - A pixel stream with continuous valid keeps CS low throughout.
  - Back-to-back byte period = 17·CLK_DIV cycles.
- Undefined: no early ready. Every byte is framed by CS high for CLK_DIV cycles (GAP), giving a period of 18·CLK_DIV+1 cycles.

Test Plan:
- Reset values: hold rst_n=0 for 3 cycles -> cs_n=1, sck=0, mosi=0, done=0, busy=0, in_ready=0. One cycle after release -> in_ready=1.
- Command byte, CLK_DIV=2: send dc=0, data=0xCB -> MOSI sampled on 8 SCK rises = 1,1,0,0,1,0,1,1; spi_dc=0 throughout CS low; done single pulse at cycle 35; in_ready at cycle 37.
- Data byte with hold: send dc=1, 0x55, then change in_data to 0xFF while busy -> wire shows 0x55, dc=1. in_valid held during busy -> no second accept until in_ready=1.
- CLK_DIV=1 sequence: words 0x36/dc0, then 0x48/dc1 -> two framed bytes, correct dc per byte, done at cycle 18 after each accept.
- Reset mid-byte: assert rst_n=0 after 4 SCK rises of 0xAA -> next edge cs_n=1, sck=0, no done; the next accepted 0x00 is transmitted correctly.
- Burst (macro defined): continuous valid with 0xAA, 0x00, 0xAA, dc=1 -> cs_n low continuously across all 24 SCK rises, 3 done pulses spaced 17·CLK_DIV cycles. Without the macro, a CS-high gap of CLK_DIV cycles appears between bytes.

Source files
------------

// File: rtl/ili9341_spi_tx_if.sv
// ili9341_spi_tx_if: word handshake and status between the ILI9341 sequencer and the SPI transmitter
interface ili9341_spi_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_dc;
    logic [7:0] in_data;
    logic       done;
    logic       busy;

    modport master (output in_valid, in_dc, in_data, input in_ready, done, busy);
    modport slave  (input in_valid, in_dc, in_data, output in_ready, done, busy);
endinterface

// File: rtl/ili9341_spi_tx.sv
// ili9341_spi_tx: byte-level SPI mode-0 transmitter for the ILI9341 panel; define ILI9341_SPI_BURST_EN to keep CS low across back-to-back words
module ili9341_spi_tx #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    ili9341_spi_tx_if.slave   bus,
    output logic              spi_sck_o,
    output logic              spi_mosi_o,
    output logic              spi_dc_o,
    output logic              spi_cs_n_o
);
    localparam int unsigned    CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          dc_q, dc_d;
    logic          done_q, done_d;
    logic          run_q;
    logic          last;
    logic          ready;
    logic          accept;
    logic          on_wire;

    assign last = cnt_q == CNT_LAST;
`ifdef ILI9341_SPI_BURST_EN
    assign ready = run_q & ((state_q == IDLE) | ((state_q == HOLD) & last));
`else
    assign ready = run_q & (state_q == IDLE);
`endif
    assign accept  = bus.in_valid & ready;
    assign on_wire = (state_q == LOW) | (state_q == HIGH);

    assign bus.in_ready = ready;
    assign bus.done     = done_q;
    assign bus.busy     = state_q != IDLE;
    assign spi_sck_o    = state_q == HIGH;
    assign spi_mosi_o   = on_wire & shift_q[idx_q];
    assign spi_dc_o     = dc_q;
    assign spi_cs_n_o   = !(on_wire | (state_q == HOLD));

    // State, counters and latched word; run_q holds in_ready low until the first cycle after reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dc_q    <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dc_q    <= dc_d;
            done_q  <= done_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state: each non-idle phase lasts CLK_DIV cycles; bits go out MSB first
    always_comb begin
        state_d = state_q;
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        dc_d    = dc_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = LOW;
                    idx_d   = 3'd7;
                    shift_d = bus.in_data;
                    dc_d    = bus.in_dc;
                end
            end
            LOW:  if (last) state_d = HIGH;
            HIGH: begin
                if (last) begin
                    state_d = (idx_q == 3'd0) ? HOLD : LOW;
                    idx_d   = (idx_q == 3'd0) ? idx_q : idx_q - 3'd1;
                end
            end
            HOLD: begin
                if (last) begin
                    done_d  = 1'b1;
                    state_d = GAP;
                    if (accept) begin
                        state_d = LOW;
                        idx_d   = 3'd7;
                        shift_d = bus.in_data;
                        dc_d    = bus.in_dc;
                    end
                end
            end
            GAP:  if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ili9341_spi_tx.sv
// tb_ili9341_spi_tx: directed checks of the ILI9341 SPI transmitter at CLK_DIV=2 and CLK_DIV=1
module tb_ili9341_spi_tx;
`ifdef ILI9341_SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   sel = 1'b0;

    logic a_sck, a_mosi, a_dc, a_cs_n;
    logic b_sck, b_mosi, b_dc, b_cs_n;
    logic s_sck, s_mosi, s_dc, s_cs_n, s_done, s_busy, s_ready;

    ili9341_spi_tx_if a_if ();
    ili9341_spi_tx_if b_if ();

    ili9341_spi_tx #(.CLK_DIV(2)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .bus(a_if.slave),
        .spi_sck_o(a_sck), .spi_mosi_o(a_mosi), .spi_dc_o(a_dc), .spi_cs_n_o(a_cs_n)
    );

    ili9341_spi_tx #(.CLK_DIV(1)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .bus(b_if.slave),
        .spi_sck_o(b_sck), .spi_mosi_o(b_mosi), .spi_dc_o(b_dc), .spi_cs_n_o(b_cs_n)
    );

    always #5 clk = ~clk;

    assign s_sck   = sel ? b_sck         : a_sck;
    assign s_mosi  = sel ? b_mosi        : a_mosi;
    assign s_dc    = sel ? b_dc          : a_dc;
    assign s_cs_n  = sel ? b_cs_n        : a_cs_n;
    assign s_done  = sel ? b_if.done     : a_if.done;
    assign s_busy  = sel ? b_if.busy     : a_if.busy;
    assign s_ready = sel ? b_if.in_ready : a_if.in_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit dc, input logic [7:0] d);
        if (sel) begin
            b_if.in_valid = v; b_if.in_dc = dc; b_if.in_data = d;
        end else begin
            a_if.in_valid = v; a_if.in_dc = dc; a_if.in_data = d;
        end
    endtask

    // One framed byte; with hold, valid stays high and data/dc change after accept until ready returns
    task automatic xfer(input bit b, input bit dc, input logic [7:0] d, input bit hold);
        int dv, rises, ndone, dcyc, rcyc, dcbad, busylo;
        logic prev;
        logic [7:0] bits;
        sel = b;
        dv = b ? 1 : 2;
        #1;
        chk("ready_pre", s_ready, 1);
        drive(1'b1, dc, d);
        rises = 0; ndone = 0; dcyc = 0; rcyc = 0; dcbad = 0; busylo = 0; prev = 1'b0; bits = '0;
        for (int k = 1; k <= 1 + 18 * dv; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                if (hold) drive(1'b1, !dc, 8'hFF);
                else drive(1'b0, dc, d);
            end
            if (s_sck && !prev) begin
                bits = {bits[6:0], s_mosi};
                rises++;
            end
            prev = s_sck;
            if (!s_cs_n && s_dc !== dc) dcbad++;
            if (s_done) begin
                ndone++;
                dcyc = k;
            end
            if (s_ready && rcyc == 0) begin
                rcyc = k;
                drive(1'b0, dc, d);
            end
            if (k <= 18 * dv && !s_busy) busylo++;
        end
        chk("bits", bits, d);
        chk("rises", rises, 8);
        chk("dc_stable", dcbad, 0);
        chk("done_count", ndone, 1);
        chk("done_cycle", dcyc, 1 + 17 * dv);
        chk("ready_cycle", rcyc, BURST ? 17 * dv : 18 * dv + 1);
        chk("busy_hold", busylo, 0);
        chk("busy_idle", s_busy, 0);
    endtask

    initial begin
        int rises, dcnt, n_edge, dones, cs_hi, prises;
        int dcyc [3];
        bit acc_pend;
        logic prev;
        logic [23:0] bits;
        logic [7:0] words [3];
        words[0] = 8'hAA; words[1] = 8'h00; words[2] = 8'hAA;
        a_if.in_valid = 0; a_if.in_dc = 0; a_if.in_data = 0;
        b_if.in_valid = 0; b_if.in_dc = 0; b_if.in_data = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", a_cs_n, 1);
        chk("rst_sck", a_sck, 0);
        chk("rst_mosi", a_mosi, 0);
        chk("rst_done", a_if.done, 0);
        chk("rst_busy", a_if.busy, 0);
        chk("rst_ready", a_if.in_ready, 0);
        chk("rst_dc", a_dc, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", a_if.in_ready, 1);

        xfer(1'b0, 1'b0, 8'hCB, 1'b0);
        xfer(1'b0, 1'b1, 8'h55, 1'b1);
        xfer(1'b1, 1'b0, 8'h36, 1'b0);
        xfer(1'b1, 1'b1, 8'h48, 1'b0);

        sel = 1'b0;
        #1;
        drive(1'b1, 1'b0, 8'hAA);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'hAA);
        rises = 0; prev = 1'b0; dcnt = 0;
        for (int k = 0; k < 100 && rises < 4; k++) begin
            if (a_sck && !prev) rises++;
            prev = a_sck;
            if (a_if.done) dcnt++;
            if (rises < 4) begin
                @(posedge clk); #1;
            end
        end
        chk("mid_rises", rises, 4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_cs_n", a_cs_n, 1);
        chk("mid_sck", a_sck, 0);
        chk("mid_busy", a_if.busy, 0);
        chk("mid_ready", a_if.in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            if (a_if.done) dcnt++;
            @(posedge clk); #1;
        end
        chk("mid_no_done", dcnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_ready_after", a_if.in_ready, 1);
        xfer(1'b0, 1'b0, 8'h00, 1'b0);

        sel = 1'b0;
        drive(1'b1, 1'b1, words[0]);
        acc_pend = 0; n_edge = 0; dones = 0; cs_hi = 0; prises = 0; prev = 1'b0; bits = '0;
        dcyc[0] = 0; dcyc[1] = 0; dcyc[2] = 0;
        for (int c = 0; c < 130; c++) begin
            if (acc_pend) begin
                acc_pend = 0;
                n_edge++;
                if (n_edge < 3) drive(1'b1, 1'b1, words[n_edge]);
                else drive(1'b0, 1'b1, 8'h00);
            end
            if (a_sck && !prev) begin
                bits = {bits[22:0], a_mosi};
                prises++;
            end
            prev = a_sck;
            if (n_edge >= 1 && dones < 3 && !a_if.done && a_cs_n) cs_hi++;
            if (a_if.done) begin
                if (dones < 3) dcyc[dones] = c;
                dones++;
            end
            if (a_if.in_valid && a_if.in_ready) acc_pend = 1;
            @(posedge clk); #1;
        end
        chk("burst_bits", bits, 24'hAA00AA);
        chk("burst_rises", prises, 24);
        chk("burst_dones", dones, 3);
        chk("burst_space1", dcyc[1] - dcyc[0], BURST ? 34 : 37);
        chk("burst_space2", dcyc[2] - dcyc[1], BURST ? 34 : 37);
        chk("burst_cs_gap", cs_hi, BURST ? 0 : 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
